// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and shadow-pipeline entry type for the decode-stage
// hazard / control-flow controller.
package pipe_ctrl_pkg;

  // Widest register tag a shadow entry can hold; narrower tags are zero-extended.
  localparam int TAG_MAX_W = 8;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  localparam logic [1:0] PC_NEXT = 2'b00;
  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_JMP  = 2'b10;
  localparam logic [1:0] PC_FOR  = 2'b11;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] rd;
    logic                 regwr;
    logic                 memr;
  } shadow_entry_t;

endpackage

// File: rtl/hazard_controller_if.sv
// Decode-stage bundle between the ID stage (master) and the hazard
// controller (slave).
interface hazard_controller_if #(
  parameter int REG_BITS = 3,
  parameter int CNT_BITS = 16
);
  logic [REG_BITS-1:0] id_rs1;
  logic [REG_BITS-1:0] id_rs2;
  logic                id_rs1_used;
  logic                id_rs2_used;
  logic [REG_BITS-1:0] id_rd;
  logic                id_regwr;
  logic                id_memr;
  logic                id_jump;
  logic                id_call;
  logic                id_ret;
  logic                id_branch;
  logic                id_for;
  logic                comp_res;
  logic [1:0]          ForwardA;
  logic [1:0]          ForwardB;
  logic                stall;
  logic                kill;
  logic                ex_bubble;
  logic [1:0]          pc_sel;
  logic                JumpSrc;
  logic                RRWE;
  logic [CNT_BITS-1:0] num_stalls;
  logic [CNT_BITS-1:0] num_kills;

  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_regwr, id_memr,
           id_jump, id_call, id_ret, id_branch, id_for, comp_res,
    input  ForwardA, ForwardB, stall, kill, ex_bubble, pc_sel, JumpSrc, RRWE,
           num_stalls, num_kills
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_regwr, id_memr,
           id_jump, id_call, id_ret, id_branch, id_for, comp_res,
    output ForwardA, ForwardB, stall, kill, ex_bubble, pc_sel, JumpSrc, RRWE,
           num_stalls, num_kills
  );
endinterface

// File: rtl/fwd_select.sv
// Per-source forwarding select: newest matching in-flight writer wins,
// and a match on a load in EX is flagged as a load-use hit.
module fwd_select
  import pipe_ctrl_pkg::*;
(
  input  logic [TAG_MAX_W-1:0] tag,
  input  logic                 used,
  input  shadow_entry_t        ex_e,
  input  shadow_entry_t        mem_e,
  input  shadow_entry_t        wb_e,
  output logic [1:0]           fwd,
  output logic                 load_hit
);

  function automatic logic stage_hit(input shadow_entry_t e,
                                     input logic [TAG_MAX_W-1:0] t,
                                     input logic u);
    return u && (t != {TAG_MAX_W{1'b0}}) && e.valid && e.regwr && (e.rd == t);
  endfunction

  logic ex_hit_s;
  logic mem_hit_s;
  logic wb_hit_s;
  logic unused_ok_s;

  // Only the EX entry's load flag matters; older loads have already returned.
  assign unused_ok_s = ^{mem_e.memr, wb_e.memr};

  // Priority select of the forwarding source.
  always_comb begin
    ex_hit_s  = stage_hit(ex_e, tag, used);
    mem_hit_s = stage_hit(mem_e, tag, used);
    wb_hit_s  = stage_hit(wb_e, tag, used);
    load_hit  = ex_hit_s && ex_e.memr;
    fwd       = FWD_RF;
    if (ex_hit_s && !ex_e.memr) begin
      fwd = FWD_EX;
    end else if (mem_hit_s) begin
      fwd = FWD_MEM;
    end else if (wb_hit_s) begin
      fwd = FWD_WB;
    end else begin
      fwd = FWD_RF;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Decode-stage hazard and control-flow controller: shadow EX/MEM/WB tag
// pipeline, load-use stall, forwarding selects, redirects and counters.
module hazard_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_BITS = 3,
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  hazard_controller_if.slave  bus
);

  shadow_entry_t        ex_r, mem_r, wb_r;
  logic                 kill_q_r;
  logic [CNT_BITS-1:0]  num_stalls_r, num_kills_r;

  logic [TAG_MAX_W-1:0] rs1_tag_s, rs2_tag_s, rd_tag_s;
  logic [1:0]           fwd_a_s, fwd_b_s, pc_sel_s;
  logic                 load_hit_a_s, load_hit_b_s;
  logic                 id_valid_s, stall_s, kill_s, jump_src_s, rrwe_s;

  assign rs1_tag_s  = TAG_MAX_W'(bus.id_rs1);
  assign rs2_tag_s  = TAG_MAX_W'(bus.id_rs2);
  assign rd_tag_s   = TAG_MAX_W'(bus.id_rd);
  // The slot right after a redirect holds a squashed fetch.
  assign id_valid_s = ~kill_q_r;
  assign stall_s    = id_valid_s & (load_hit_a_s | load_hit_b_s);

  fwd_select u_fwd_a (
    .tag(rs1_tag_s), .used(bus.id_rs1_used), .ex_e(ex_r), .mem_e(mem_r),
    .wb_e(wb_r), .fwd(fwd_a_s), .load_hit(load_hit_a_s)
  );

  fwd_select u_fwd_b (
    .tag(rs2_tag_s), .used(bus.id_rs2_used), .ex_e(ex_r), .mem_e(mem_r),
    .wb_e(wb_r), .fwd(fwd_b_s), .load_hit(load_hit_b_s)
  );

  // Redirect decode; a stalled or squashed slot never redirects.
  always_comb begin
    kill_s     = 1'b0;
    pc_sel_s   = PC_NEXT;
    jump_src_s = 1'b0;
    rrwe_s     = 1'b0;
    if (id_valid_s && !stall_s) begin
      if (bus.id_jump || bus.id_call) begin
        pc_sel_s = PC_JMP;
        kill_s   = 1'b1;
        rrwe_s   = bus.id_call;
      end else if (bus.id_ret) begin
        pc_sel_s   = PC_JMP;
        jump_src_s = 1'b1;
        kill_s     = 1'b1;
      end else if (bus.id_branch && bus.comp_res) begin
        pc_sel_s = PC_BR;
        kill_s   = 1'b1;
      end else if (bus.id_for && !bus.comp_res) begin
        pc_sel_s = PC_FOR;
        kill_s   = 1'b1;
      end else begin
        pc_sel_s = PC_NEXT;
        kill_s   = 1'b0;
      end
    end else begin
      pc_sel_s = PC_NEXT;
      kill_s   = 1'b0;
    end
  end

  // Output drive; everything reads zero while reset is held.
  always_comb begin
    bus.ForwardA   = FWD_RF;
    bus.ForwardB   = FWD_RF;
    bus.stall      = 1'b0;
    bus.kill       = 1'b0;
    bus.ex_bubble  = 1'b0;
    bus.pc_sel     = PC_NEXT;
    bus.JumpSrc    = 1'b0;
    bus.RRWE       = 1'b0;
    bus.num_stalls = {CNT_BITS{1'b0}};
    bus.num_kills  = {CNT_BITS{1'b0}};
    if (!reset) begin
      bus.ForwardA   = (id_valid_s && !stall_s) ? fwd_a_s : FWD_RF;
      bus.ForwardB   = (id_valid_s && !stall_s) ? fwd_b_s : FWD_RF;
      bus.stall      = stall_s;
      bus.kill       = kill_s;
      bus.ex_bubble  = stall_s | ~id_valid_s;
      bus.pc_sel     = pc_sel_s;
      bus.JumpSrc    = jump_src_s;
      bus.RRWE       = rrwe_s;
      bus.num_stalls = num_stalls_r;
      bus.num_kills  = num_kills_r;
    end else begin
      bus.ex_bubble  = 1'b0;
    end
  end

  // Shadow pipeline advance, squash flag and performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_r         <= '0;
      mem_r        <= '0;
      wb_r         <= '0;
      kill_q_r     <= 1'b0;
      num_stalls_r <= {CNT_BITS{1'b0}};
      num_kills_r  <= {CNT_BITS{1'b0}};
    end else begin
      wb_r         <= mem_r;
      mem_r        <= ex_r;
      ex_r         <= '{valid: id_valid_s & ~stall_s, rd: rd_tag_s,
                        regwr: bus.id_regwr, memr: bus.id_memr};
      kill_q_r     <= kill_s;
      num_stalls_r <= stall_s ? num_stalls_r + CNT_BITS'(1) : num_stalls_r;
      num_kills_r  <= kill_s ? num_kills_r + CNT_BITS'(1) : num_kills_r;
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: directed per-cycle ID vectors with
// hand-computed expected outputs, checked by an independent monitor.
module tb_hazard_controller;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  hazard_controller_if #(.REG_BITS(3), .CNT_BITS(16)) bus ();

  hazard_controller #(.REG_BITS(3), .CNT_BITS(16)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct packed {
    logic [7:0]  id;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        st;
    logic        kl;
    logic        bub;
    logic [1:0]  pc;
    logic        js;
    logic        rr;
    logic [15:0] ns;
    logic [15:0] nk;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_n  = 0;

  // Control-flow classes: 0 seq, 1 jump, 2 call, 3 ret, 4 branch, 5 for
  task automatic cyc(input logic rst,
                     input logic [2:0] rs1, input logic u1,
                     input logic [2:0] rs2, input logic u2,
                     input logic [2:0] rd, input logic wr, input logic ld,
                     input logic [2:0] cf, input logic cmp,
                     input logic [1:0] fa, input logic [1:0] fb,
                     input logic st, input logic kl, input logic bub,
                     input logic [1:0] pc, input logic js, input logic rr,
                     input logic [15:0] ns, input logic [15:0] nk);
    exp_t e;
    @(posedge clk);
    #1;
    reset           = rst;
    bus.id_rs1      = rs1;
    bus.id_rs1_used = u1;
    bus.id_rs2      = rs2;
    bus.id_rs2_used = u2;
    bus.id_rd       = rd;
    bus.id_regwr    = wr;
    bus.id_memr     = ld;
    bus.id_jump     = (cf == 3'd1);
    bus.id_call     = (cf == 3'd2);
    bus.id_ret      = (cf == 3'd3);
    bus.id_branch   = (cf == 3'd4);
    bus.id_for      = (cf == 3'd5);
    bus.comp_res    = cmp;
    e = '{id: 8'(vec_n), fa: fa, fb: fb, st: st, kl: kl, bub: bub, pc: pc,
          js: js, rr: rr, ns: ns, nk: nk};
    sb_q.push_back(e);
    vec_n++;
  endtask

  task automatic chk(input string nm, input logic [7:0] id,
                     input logic [15:0] act, input logic [15:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s vec %0d: got %0h expected %0h", nm, id, act, exp_v);
    end
  endtask

  // Monitor: one expected record per cycle, compared away from the clock edge.
  always @(negedge clk) begin : mon
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("ForwardA",   e.id, {14'd0, bus.ForwardA}, {14'd0, e.fa});
      chk("ForwardB",   e.id, {14'd0, bus.ForwardB}, {14'd0, e.fb});
      chk("stall",      e.id, {15'd0, bus.stall},    {15'd0, e.st});
      chk("kill",       e.id, {15'd0, bus.kill},     {15'd0, e.kl});
      chk("ex_bubble",  e.id, {15'd0, bus.ex_bubble}, {15'd0, e.bub});
      chk("pc_sel",     e.id, {14'd0, bus.pc_sel},   {14'd0, e.pc});
      chk("JumpSrc",    e.id, {15'd0, bus.JumpSrc},  {15'd0, e.js});
      chk("RRWE",       e.id, {15'd0, bus.RRWE},     {15'd0, e.rr});
      chk("num_stalls", e.id, bus.num_stalls, e.ns);
      chk("num_kills",  e.id, bus.num_kills,  e.nk);
    end
  end

  // Control-flow class inputs must be one-hot or idle.
  always @(negedge clk) begin
    assert ($onehot0({bus.id_jump, bus.id_call, bus.id_ret, bus.id_branch, bus.id_for}))
      else $error("illegal multiple control-flow classes");
  end

  initial begin
    bus.id_rs1 = 3'd0; bus.id_rs1_used = 1'b0; bus.id_rs2 = 3'd0; bus.id_rs2_used = 1'b0;
    bus.id_rd = 3'd0; bus.id_regwr = 1'b0; bus.id_memr = 1'b0; bus.id_jump = 1'b0;
    bus.id_call = 1'b0; bus.id_ret = 1'b0; bus.id_branch = 1'b0; bus.id_for = 1'b0;
    bus.comp_res = 1'b0;
    //  rst rs1 u1 rs2 u2 rd wr ld cf cmp |  fa    fb    st kl bub pc    js rr ns nk
    cyc(1, 0,0, 0,0, 0,0,0, 0,0, 2'b00,2'b00, 0,0,0, 2'b00, 0,0, 0,0); // 0 reset
    cyc(1, 0,0, 0,0, 0,0,0, 0,0, 2'b00,2'b00, 0,0,0, 2'b00, 0,0, 0,0); // 1 reset
    cyc(0, 0,0, 0,0, 0,0,0, 0,0, 2'b00,2'b00, 0,0,0, 2'b00, 0,0, 0,0); // 2 empty pipe
    cyc(0, 2,1, 3,1, 1,1,0, 0,0, 2'b00,2'b00, 0,0,0, 2'b00, 0,0, 0,0); // 3 ADD R1
    cyc(0, 1,1, 3,1, 2,1,0, 0,0, 2'b01,2'b00, 0,0,0, 2'b00, 0,0, 0,0); // 4 R1 from EX
    cyc(0, 1,1, 0,0, 5,1,0, 0,0, 2'b10,2'b00, 0,0,0, 2'b00, 0,0, 0,0); // 5 R1 from MEM
    cyc(0, 1,1, 2,1, 6,1,0, 0,0, 2'b11,2'b10, 0,0,0, 2'b00, 0,0, 0,0); // 6 R1 WB, R2 MEM
    cyc(0, 5,1, 0,0, 4,1,1, 0,0, 2'b10,2'b00, 0,0,0, 2'b00, 0,0, 0,0); // 7 LW R4
    cyc(0, 6,1, 4,1, 0,0,0, 0,0, 2'b00,2'b00, 1,0,1, 2'b00, 0,0, 0,0); // 8 SW load-use
    cyc(0, 6,1, 4,1, 0,0,0, 0,0, 2'b11,2'b10, 0,0,0, 2'b00, 0,0, 1,0); // 9 SW resumes
    cyc(0, 0,0, 0,0, 0,0,0, 2,0, 2'b00,2'b00, 0,1,0, 2'b10, 0,1, 1,0); // 10 CALL
    cyc(0, 6,1, 0,0, 0,0,0, 3,0, 2'b00,2'b00, 0,0,1, 2'b00, 0,0, 1,1); // 11 squashed
    cyc(0, 0,0, 0,0, 0,0,0, 3,0, 2'b00,2'b00, 0,1,0, 2'b10, 1,0, 1,1); // 12 RET
    cyc(0, 0,0, 0,0, 0,0,0, 1,0, 2'b00,2'b00, 0,0,1, 2'b00, 0,0, 1,2); // 13 jump squashed
    cyc(0, 0,0, 0,0, 3,1,1, 0,0, 2'b00,2'b00, 0,0,0, 2'b00, 0,0, 1,2); // 14 LW R3
    cyc(0, 3,1, 0,1, 0,0,0, 4,1, 2'b00,2'b00, 1,0,1, 2'b00, 0,0, 1,2); // 15 BR waits
    cyc(0, 3,1, 0,1, 0,0,0, 4,1, 2'b10,2'b00, 0,1,0, 2'b01, 0,0, 2,2); // 16 BR taken
    cyc(0, 0,0, 0,0, 0,0,0, 0,0, 2'b00,2'b00, 0,0,1, 2'b00, 0,0, 2,3); // 17 squashed
    cyc(0, 0,0, 0,0, 0,0,0, 5,1, 2'b00,2'b00, 0,0,0, 2'b00, 0,0, 2,3); // 18 FOR cmp=1
    cyc(0, 0,0, 0,0, 5,1,0, 0,0, 2'b00,2'b00, 0,0,0, 2'b00, 0,0, 2,3); // 19 ADD R5
    cyc(0, 5,1, 0,0, 0,0,0, 5,0, 2'b01,2'b00, 0,1,0, 2'b11, 0,0, 2,3); // 20 FOR + EX fwd
    cyc(0, 0,0, 0,0, 0,0,0, 0,0, 2'b00,2'b00, 0,0,1, 2'b00, 0,0, 2,4); // 21 squashed
    cyc(0, 5,1, 0,0, 0,0,0, 4,0, 2'b11,2'b00, 0,0,0, 2'b00, 0,0, 2,4); // 22 BR not taken
    cyc(0, 0,0, 0,0, 6,1,0, 0,0, 2'b00,2'b00, 0,0,0, 2'b00, 0,0, 2,4); // 23 ADD R6
    cyc(0, 0,0, 0,0, 6,1,0, 0,0, 2'b00,2'b00, 0,0,0, 2'b00, 0,0, 2,4); // 24 ADD R6
    cyc(0, 6,1, 0,0, 6,1,0, 0,0, 2'b01,2'b00, 0,0,0, 2'b00, 0,0, 2,4); // 25 ADD R6 rd R6
    cyc(0, 6,1, 0,0, 6,1,1, 0,0, 2'b01,2'b00, 0,0,0, 2'b00, 0,0, 2,4); // 26 R6 x3, EX wins
    cyc(0, 0,0, 6,1, 0,1,0, 0,0, 2'b00,2'b00, 1,0,1, 2'b00, 0,0, 2,4); // 27 EX load stalls
    cyc(0, 0,0, 6,1, 0,1,0, 0,0, 2'b00,2'b10, 0,0,0, 2'b00, 0,0, 3,4); // 28 MEM newest
    cyc(0, 0,1, 0,1, 0,0,0, 0,0, 2'b00,2'b00, 0,0,0, 2'b00, 0,0, 3,4); // 29 R0 reader
    cyc(0, 0,0, 0,0, 2,1,1, 0,0, 2'b00,2'b00, 0,0,0, 2'b00, 0,0, 3,4); // 30 LW R2
    cyc(1, 2,1, 0,0, 1,1,0, 0,0, 2'b00,2'b00, 0,0,0, 2'b00, 0,0, 0,0); // 31 reset mid-stall
    cyc(0, 2,1, 0,0, 1,1,0, 0,0, 2'b00,2'b00, 0,0,0, 2'b00, 0,0, 0,0); // 32 no stale fwd
    cyc(0, 0,0, 0,0, 0,0,0, 1,0, 2'b00,2'b00, 0,1,0, 2'b10, 0,0, 0,0); // 33 JUMP
    cyc(1, 0,0, 0,0, 0,0,0, 0,0, 2'b00,2'b00, 0,0,0, 2'b00, 0,0, 0,0); // 34 reset mid-kill
    cyc(0, 0,0, 0,0, 0,0,0, 1,0, 2'b00,2'b00, 0,1,0, 2'b10, 0,0, 0,0); // 35 JUMP not squashed
    cyc(0, 0,0, 0,0, 0,0,0, 0,0, 2'b00,2'b00, 0,0,1, 2'b00, 0,0, 0,1); // 36 squashed
    cyc(0, 0,0, 0,0, 0,0,0, 0,0, 2'b00,2'b00, 0,0,0, 2'b00, 0,0, 0,1); // 37 sequential
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected records left, wanted 0", sb_q.size());
    end
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
